// File: rtl/stk_ram_pkg.sv
// rtl/stk_ram_pkg.sv - shared types and helpers for the spill-RAM arbiter
package stk_ram_pkg;

    localparam int NREQ_DEF = 2;
    localparam int SRC_N    = 2 * NREQ_DEF;
    localparam int SRC_W    = $clog2(SRC_N);

    typedef logic [SRC_W-1:0] stk_src_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // First set bit of req searching last+1, last+2, ... modulo SRC_N.
    function automatic stk_src_t rr_pick(input logic [SRC_N-1:0] req, input stk_src_t last);
        stk_src_t pick;
        int idx;
        pick = last;
        for (int k = SRC_N; k >= 1; k--) begin
            idx = (int'(last) + k) % SRC_N;
            if (req[idx]) pick = stk_src_t'(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/stk_rr_pick.sv
// rtl/stk_rr_pick.sv - combinational round-robin priority picker
module stk_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] gnt,
    output logic         any
);

    int idx;

    // Walk from farthest to nearest so the source just after last wins.
    always_comb begin
        gnt = last;
        any = |req;
        idx = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) gnt = W'(idx);
        end
    end

endmodule

// File: rtl/stk_ram_arbiter.sv
// rtl/stk_ram_arbiter.sv - burst-locked round-robin arbiter for a shared spill SRAM
module stk_ram_arbiter
    import stk_ram_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DW    = 98,
    parameter int AW    = 5,
    parameter int BURST = 4,
    parameter int RAW   = $clog2(NREQ > 2 ? NREQ : 2) + AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_clear,
    input  logic [NREQ-1:0]    req_rd_vld,
    input  logic [NREQ*AW-1:0] req_rd_adr,
    output logic [NREQ-1:0]    req_rd_rdy,
    output logic [NREQ-1:0]    req_rd_ack,
    output logic [DW-1:0]      rd_dat,
    input  logic [NREQ-1:0]    req_wr_vld,
    input  logic [NREQ*AW-1:0] req_wr_adr,
    input  logic [NREQ*DW-1:0] req_wr_dat,
    output logic [NREQ-1:0]    req_wr_rdy,
    output logic               ram_en,
    output logic               ram_we,
    output logic [RAW-1:0]     ram_adr,
    output logic [DW-1:0]      ram_wdat,
    input  logic [DW-1:0]      ram_rdat,
    output logic               busy
);

    localparam int SN = 2 * NREQ;
    localparam int SW = $clog2(SN);
    localparam int IW = RAW - AW;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_e      state;
    logic [SW-1:0]   last_src;
    logic [SW-1:0]   grant_src;
    logic [BW-1:0]   beat_cnt;
    logic            ack_pend;
    logic [IW-1:0]   ack_id;

    logic [SN-1:0]   src_req;
    logic [SW-1:0]   pick_src;
    logic            pick_any;
    logic [IW-1:0]   gnt_req;
    logic            g_wr;
    logic            g_vld;
    logic            g_clr;
    logic [AW-1:0]   g_adr;
    logic            beat;

    // Even sources are fill (read) channels, odd sources are spill (write) channels.
    always_comb begin
        src_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_req[2*i]   = req_rd_vld[i] && !req_clear[i];
            src_req[2*i+1] = req_wr_vld[i] && !req_clear[i];
        end
    end

    stk_rr_pick #(.N(SN), .W(SW)) u_pick (
        .req  (src_req),
        .last (last_src),
        .gnt  (pick_src),
        .any  (pick_any)
    );

    always_comb begin
        gnt_req = IW'(grant_src >> 1);
        g_wr    = grant_src[0];
        g_vld   = g_wr ? req_wr_vld[gnt_req] : req_rd_vld[gnt_req];
        g_clr   = req_clear[gnt_req];
        g_adr   = g_wr ? req_wr_adr[gnt_req*AW +: AW] : req_rd_adr[gnt_req*AW +: AW];
        beat    = (state == GRANT) && g_vld && !g_clr;
    end

    always_comb begin
        req_rd_rdy = '0;
        req_wr_rdy = '0;
        if (beat) begin
            if (g_wr) req_wr_rdy[gnt_req] = 1'b1;
            else      req_rd_rdy[gnt_req] = 1'b1;
        end
        ram_en   = beat;
        ram_we   = beat && g_wr;
        ram_adr  = beat ? {gnt_req, g_adr} : '0;
        ram_wdat = (beat && g_wr) ? req_wr_dat[gnt_req*DW +: DW] : '0;
    end

    // A flush of the target requester in the return cycle swallows its ack.
    always_comb begin
        req_rd_ack = '0;
        if (ack_pend && !req_clear[ack_id]) req_rd_ack[ack_id] = 1'b1;
        rd_dat = ack_pend ? ram_rdat : '0;
        busy   = (state == GRANT) || ack_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_src  <= SW'(SN - 1);
            grant_src <= '0;
            beat_cnt  <= '0;
            ack_pend  <= 1'b0;
            ack_id    <= '0;
        end else begin
            ack_pend <= beat && !g_wr;
            if (beat && !g_wr) ack_id <= gnt_req;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_src <= pick_src;
                        beat_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (g_clr || !g_vld || (beat && beat_cnt == BW'(BURST - 1))) begin
                        state    <= IDLE;
                        last_src <= grant_src;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stk_ram_arbiter.sv
// tb/tb_stk_ram_arbiter.sv - directed self-checking bench for stk_ram_arbiter
module tb_stk_ram_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req_clear;
    logic [1:0]   req_rd_vld;
    logic [9:0]   req_rd_adr;
    logic [1:0]   req_rd_rdy;
    logic [1:0]   req_rd_ack;
    logic [97:0]  rd_dat;
    logic [1:0]   req_wr_vld;
    logic [9:0]   req_wr_adr;
    logic [195:0] req_wr_dat;
    logic [1:0]   req_wr_rdy;
    logic         ram_en;
    logic         ram_we;
    logic [5:0]   ram_adr;
    logic [97:0]  ram_wdat;
    logic [97:0]  ram_rdat;
    logic         busy;
    logic [3:0]   src_rdy;

    int checks;
    int failures;

    logic [97:0] mem [64];

    stk_ram_arbiter #(.NREQ(2), .DW(98), .AW(5), .BURST(4), .RAW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_clear  (req_clear),
        .req_rd_vld (req_rd_vld),
        .req_rd_adr (req_rd_adr),
        .req_rd_rdy (req_rd_rdy),
        .req_rd_ack (req_rd_ack),
        .rd_dat     (rd_dat),
        .req_wr_vld (req_wr_vld),
        .req_wr_adr (req_wr_adr),
        .req_wr_dat (req_wr_dat),
        .req_wr_rdy (req_wr_rdy),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_adr    (ram_adr),
        .ram_wdat   (ram_wdat),
        .ram_rdat   (ram_rdat),
        .busy       (busy)
    );

    assign src_rdy = {req_wr_rdy[1], req_rd_rdy[1], req_wr_rdy[0], req_rd_rdy[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM with one-cycle read latency.
    initial ram_rdat = '0;
    always @(posedge clk) begin
        if (ram_en && ram_we)  mem[ram_adr] <= ram_wdat;
        if (ram_en && !ram_we) ram_rdat <= mem[ram_adr];
    end

    function automatic logic [97:0] dpat(input int i, input int a);
        return {34'h2_DEAD_BEEF, 32'(i), 32'(a)};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        #2;
        checks++; if (src_rdy !== 4'b0000) begin failures++; $display("FAIL reset_rdy got=%b exp=0000", src_rdy); end
        checks++; if (req_rd_ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", req_rd_ack); end
        checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram got=%b%b exp=00", ram_en, ram_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rd_dat !== 98'd0) begin failures++; $display("FAIL reset_rd_dat got=%h exp=0", rd_dat); end
    endtask

    task automatic test_spill();
        next();
        req_wr_vld[0] = 1'b1;
        req_wr_adr[4:0] = 5'd4;
        req_wr_dat[97:0] = dpat(0, 4);
        #2;
        checks++; if (src_rdy !== 4'b0000 || ram_en !== 1'b0) begin failures++; $display("FAIL spill_latency rdy=%b en=%b exp=0000,0", src_rdy, ram_en); end
        for (int k = 0; k < 4; k++) begin
            next();
            req_wr_adr[4:0] = 5'(4 + k);
            req_wr_dat[97:0] = dpat(0, 4 + k);
            #2;
            checks++; if (src_rdy !== 4'b0010) begin failures++; $display("FAIL spill_rdy beat=%0d got=%b exp=0010", k, src_rdy); end
            checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin failures++; $display("FAIL spill_we beat=%0d got=%b%b exp=11", k, ram_en, ram_we); end
            checks++; if (ram_adr !== 6'(4 + k)) begin failures++; $display("FAIL spill_adr beat=%0d got=%h exp=%h", k, ram_adr, 6'(4 + k)); end
            checks++; if (ram_wdat !== dpat(0, 4 + k)) begin failures++; $display("FAIL spill_wdat beat=%0d got=%h", k, ram_wdat); end
        end
        next();
        req_wr_vld[0] = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || ram_en !== 1'b0 || src_rdy !== 4'b0000) begin failures++; $display("FAIL spill_end busy=%b en=%b rdy=%b exp=0,0,0000", busy, ram_en, src_rdy); end
    endtask

    task automatic test_read_ack();
        next();
        req_wr_vld[1] = 1'b1;
        req_wr_adr[9:5] = 5'd3;
        req_wr_dat[195:98] = dpat(1, 3);
        #2;
        next();
        #2;
        checks++; if (src_rdy !== 4'b1000 || ram_adr !== 6'h23 || ram_we !== 1'b1) begin failures++; $display("FAIL wr1_beat rdy=%b adr=%h we=%b exp=1000,23,1", src_rdy, ram_adr, ram_we); end
        next();
        req_wr_vld[1] = 1'b0;
        #2;
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL wr1_short_exit en=%b exp=0", ram_en); end
        next();
        req_rd_vld[1] = 1'b1;
        req_rd_adr[9:5] = 5'd3;
        #2;
        next();
        #2;
        checks++; if (src_rdy !== 4'b0100 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_adr !== 6'h23) begin failures++; $display("FAIL rd1_beat rdy=%b en=%b we=%b adr=%h exp=0100,1,0,23", src_rdy, ram_en, ram_we, ram_adr); end
        next();
        req_rd_vld[1] = 1'b0;
        #2;
        checks++; if (req_rd_ack !== 2'b10) begin failures++; $display("FAIL rd1_ack got=%b exp=10", req_rd_ack); end
        checks++; if (rd_dat !== dpat(1, 3)) begin failures++; $display("FAIL rd1_dat got=%h exp=%h", rd_dat, dpat(1, 3)); end
        next();
        #2;
        checks++; if (req_rd_ack !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rd1_done ack=%b busy=%b exp=00,0", req_rd_ack, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rr [19];
        logic [1:0] exp_ack;
        // Single read by requester 0 leaves source 0 as the last grant.
        next();
        req_rd_vld[0] = 1'b1;
        req_rd_adr[4:0] = 5'd5;
        #2;
        next();
        #2;
        checks++; if (src_rdy !== 4'b0001 || ram_adr !== 6'h05) begin failures++; $display("FAIL rd0_beat rdy=%b adr=%h exp=0001,05", src_rdy, ram_adr); end
        next();
        req_rd_vld[0] = 1'b0;
        #2;
        checks++; if (req_rd_ack !== 2'b01 || rd_dat !== dpat(0, 5)) begin failures++; $display("FAIL rd0_ack ack=%b dat=%h exp=01,%h", req_rd_ack, rd_dat, dpat(0, 5)); end
        for (int c = 0; c < 19; c++) begin
            if (c < 4)       exp_rr[c] = 4'b0010;
            else if (c == 4) exp_rr[c] = 4'b0000;
            else if (c < 9)  exp_rr[c] = 4'b0100;
            else if (c == 9) exp_rr[c] = 4'b0000;
            else if (c < 14) exp_rr[c] = 4'b1000;
            else if (c == 14) exp_rr[c] = 4'b0000;
            else             exp_rr[c] = 4'b0010;
        end
        next();
        req_wr_vld = 2'b11;
        req_rd_vld[1] = 1'b1;
        req_wr_adr = {5'd9, 5'd8};
        req_wr_dat = {dpat(1, 9), dpat(0, 8)};
        #2;
        checks++; if (src_rdy !== 4'b0000) begin failures++; $display("FAIL rr_idle got=%b exp=0000", src_rdy); end
        for (int c = 0; c < 19; c++) begin
            next();
            #2;
            exp_ack = (c > 0 && exp_rr[c-1] == 4'b0100) ? 2'b10 : 2'b00;
            checks++; if (src_rdy !== exp_rr[c]) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, src_rdy, exp_rr[c]); end
            checks++; if (req_rd_ack !== exp_ack) begin failures++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", c, req_rd_ack, exp_ack); end
            if (exp_ack == 2'b10) begin
                checks++; if (rd_dat !== dpat(1, 3)) begin failures++; $display("FAIL rr_dat cyc=%0d got=%h", c, rd_dat); end
            end
        end
        next();
        req_wr_vld = 2'b00;
        req_rd_vld = 2'b00;
        #2;
        checks++; if (src_rdy !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rr_end rdy=%b busy=%b exp=0000,0", src_rdy, busy); end
    endtask

    task automatic test_partial();
        next();
        req_wr_vld[0] = 1'b1;
        req_wr_adr[4:0] = 5'd10;
        #2;
        next();
        req_rd_vld[1] = 1'b1;
        #2;
        checks++; if (src_rdy !== 4'b0010 || ram_adr !== 6'h0A) begin failures++; $display("FAIL part_beat1 rdy=%b adr=%h exp=0010,0a", src_rdy, ram_adr); end
        next();
        #2;
        checks++; if (src_rdy !== 4'b0010) begin failures++; $display("FAIL part_beat2 got=%b exp=0010", src_rdy); end
        next();
        req_wr_vld[0] = 1'b0;
        #2;
        checks++; if (src_rdy !== 4'b0000 || ram_en !== 1'b0) begin failures++; $display("FAIL part_drop rdy=%b en=%b exp=0000,0", src_rdy, ram_en); end
        next();
        #2;
        checks++; if (src_rdy !== 4'b0000) begin failures++; $display("FAIL part_bubble got=%b exp=0000", src_rdy); end
        next();
        #2;
        checks++; if (src_rdy !== 4'b0100 || ram_adr !== 6'h23) begin failures++; $display("FAIL part_rd rdy=%b adr=%h exp=0100,23", src_rdy, ram_adr); end
        next();
        req_rd_vld[1] = 1'b0;
        #2;
        checks++; if (req_rd_ack !== 2'b10 || rd_dat !== dpat(1, 3)) begin failures++; $display("FAIL part_ack ack=%b dat=%h exp=10", req_rd_ack, rd_dat); end
    endtask

    task automatic test_clear();
        next();
        req_rd_vld[1] = 1'b1;
        #2;
        next();
        #2;
        checks++; if (src_rdy !== 4'b0100) begin failures++; $display("FAIL clr_beat got=%b exp=0100", src_rdy); end
        next();
        req_clear[1] = 1'b1;
        #2;
        checks++; if (src_rdy !== 4'b0000 || ram_en !== 1'b0) begin failures++; $display("FAIL clr_rdy rdy=%b en=%b exp=0000,0", src_rdy, ram_en); end
        checks++; if (req_rd_ack !== 2'b00) begin failures++; $display("FAIL clr_ack got=%b exp=00", req_rd_ack); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy got=%b exp=1", busy); end
        next();
        req_clear[1] = 1'b0;
        req_rd_vld[1] = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || req_rd_ack !== 2'b00) begin failures++; $display("FAIL clr_after busy=%b ack=%b exp=0,00", busy, req_rd_ack); end
    endtask

    task automatic test_reset_mid_burst();
        next();
        req_rd_vld[1] = 1'b1;
        #2;
        next();
        #2;
        checks++; if (src_rdy !== 4'b0100) begin failures++; $display("FAIL rst_beat1 got=%b exp=0100", src_rdy); end
        next();
        rst = 1'b1;
        #2;
        next();
        rst = 1'b0;
        req_rd_vld = 2'b01;
        req_wr_vld = 2'b10;
        #2;
        checks++; if (src_rdy !== 4'b0000 || ram_en !== 1'b0) begin failures++; $display("FAIL rst_rdy rdy=%b en=%b exp=0000,0", src_rdy, ram_en); end
        checks++; if (req_rd_ack !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rst_ack ack=%b busy=%b exp=00,0", req_rd_ack, busy); end
        next();
        #2;
        checks++; if (src_rdy !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", src_rdy); end
        next();
        req_rd_vld = 2'b00;
        req_wr_vld = 2'b00;
        #2;
        checks++; if (req_rd_ack !== 2'b01 || rd_dat !== dpat(0, 5)) begin failures++; $display("FAIL rst_rd0_ack ack=%b dat=%h exp=01,%h", req_rd_ack, rd_dat, dpat(0, 5)); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_clear  = '0;
        req_rd_vld = '0;
        req_rd_adr = '0;
        req_wr_vld = '0;
        req_wr_adr = '0;
        req_wr_dat = '0;
        test_reset();
        test_spill();
        test_read_ack();
        test_round_robin();
        test_partial();
        test_clear();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
